// File: rtl/clkgen_pkg.sv
// Shared constants for the square-wave clock divider controller.
package clkgen_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] STOPPING = 2'd2;

  localparam int unsigned DEFAULT_LIMIT = 25000;
  localparam int unsigned MIN_LIMIT     = 1;

endpackage

// File: rtl/clkgen_ctrl_cfg.sv
// Divisor config port: holds one accepted divisor until the main FSM applies it.
module clkgen_ctrl_cfg #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             apply,
  output logic             cfg_ready,
  output logic             pending,
  output logic [CNT_W-1:0] shadow
);
  import clkgen_pkg::*;

  logic accept;

  assign cfg_ready = !pending;
  assign accept    = cfg_valid && !pending;

  // apply can only fire while pending is set, so it never races an accept.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      pending <= 1'b0;
    end else if (accept) begin
      shadow  <= (cfg_limit == '0) ? CNT_W'(MIN_LIMIT) : cfg_limit;
      pending <= 1'b1;
    end else if (apply) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/clkgen_ctrl.sv
// Square-wave clock divider with start/stop sequencing and glitch-free divisor updates.
module clkgen_ctrl #(
  parameter int unsigned      CNT_W         = 32,
  parameter logic [CNT_W-1:0] DEFAULT_LIMIT = CNT_W'(clkgen_pkg::DEFAULT_LIMIT)
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_limit,
  output logic             cfg_ready,
  output logic             clkout,
  output logic             tick,
  output logic             busy,
  output logic             pending
);
  import clkgen_pkg::*;

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] active_limit;
  logic [CNT_W-1:0] shadow;
  logic             toggle;
  logic             falling;
  logic             apply;

  assign cnt_next = count + CNT_W'(1);
  assign toggle   = (state != IDLE) && (cnt_next >= active_limit);
  assign falling  = toggle && clkout;
  // Divisor swaps only at the 1->0 edge (or while idle) so no half-period is cut short.
  assign apply    = pending && ((state == IDLE) || falling);
  assign busy     = (state != IDLE);

  clkgen_ctrl_cfg #(
    .CNT_W(CNT_W)
  ) u_cfg (
    .clkin    (clkin),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_limit(cfg_limit),
    .apply    (apply),
    .cfg_ready(cfg_ready),
    .pending  (pending),
    .shadow   (shadow)
  );

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      clkout       <= 1'b0;
      tick         <= 1'b0;
      active_limit <= DEFAULT_LIMIT;
    end else begin
      if (apply) begin
        active_limit <= shadow;
      end
      tick <= toggle;

      if (state == IDLE) begin
        count  <= '0;
        clkout <= 1'b0;
      end else if (toggle) begin
        count  <= '0;
        clkout <= ~clkout;
      end else begin
        count <= cnt_next;
      end

      case (state)
        IDLE: begin
          if (run) state <= RUN;
        end
        RUN: begin
          if (!run) begin
            if (!clkout && !toggle) begin
              state <= IDLE;
              count <= '0;
            end else begin
              state <= STOPPING;
            end
          end
        end
        STOPPING: begin
          if (falling)  state <= IDLE;
          else if (run) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clkgen_ctrl.sv
// Self-checking bench for clkgen_ctrl against a half-period countdown reference model.
module tb_clkgen_ctrl;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned DEF_LIM = 25000;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;

  logic             clkin     = 1'b0;
  logic             rst       = 1'b1;
  logic             run       = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_limit = '0;
  logic             cfg_ready;
  logic             clkout;
  logic             tick;
  logic             busy;
  logic             pending;

  int nchecks = 0;
  int nerr    = 0;

  int          m_mode;
  bit          m_clk, m_tick, m_pend;
  int unsigned m_left, m_lim, m_shadow;

  always #5 clkin = ~clkin;

  clkgen_ctrl #(
    .CNT_W        (CNT_W),
    .DEFAULT_LIMIT(DEF_LIM)
  ) dut (
    .clkin    (clkin),
    .rst      (rst),
    .run      (run),
    .cfg_valid(cfg_valid),
    .cfg_limit(cfg_limit),
    .cfg_ready(cfg_ready),
    .clkout   (clkout),
    .tick     (tick),
    .busy     (busy),
    .pending  (pending)
  );

  task automatic model_reset();
    m_mode = M_IDLE; m_clk = 0; m_tick = 0; m_pend = 0;
    m_lim = DEF_LIM; m_shadow = 0; m_left = DEF_LIM;
  endtask

  // m_left = clkin cycles still to go in the current half-period.
  task automatic model_step();
    bit acc, tog, fall, was_clk;
    int unsigned req;
    acc = cfg_valid && !m_pend;
    req = (cfg_limit == 0) ? 1 : int'(cfg_limit);
    if (m_mode == M_IDLE) begin
      if (m_pend) begin m_lim = m_shadow; m_pend = 0; end
      m_left = m_lim; m_clk = 0; m_tick = 0;
      if (run) m_mode = M_RUN;
    end else begin
      was_clk = m_clk;
      tog     = (m_left <= 1);
      fall    = tog && was_clk;
      m_tick  = tog;
      if (tog) begin
        if (fall && m_pend) begin m_lim = m_shadow; m_pend = 0; end
        m_clk  = !was_clk;
        m_left = m_lim;
      end else begin
        m_left = m_left - 1;
      end
      if (m_mode == M_RUN) begin
        if (!run) m_mode = (!was_clk && !tog) ? M_IDLE : M_STOP;
      end else if (fall) begin
        m_mode = M_IDLE;
      end else if (run) begin
        m_mode = M_RUN;
      end
    end
    if (acc) begin m_shadow = req; m_pend = 1; end
  endtask

  function automatic logic [4:0] expv();
    return {m_clk, m_tick, (m_mode != M_IDLE), m_pend, !m_pend};
  endfunction

  task automatic adv();
    model_step();
    @(negedge clkin);
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    nchecks++;
    if ({clkout, tick, busy, pending, cfg_ready} !== 5'b00001) begin
      nerr++;
      $display("FAIL reset_state got=%b exp=%b", {clkout, tick, busy, pending, cfg_ready}, 5'b00001);
    end
    @(negedge clkin);
    rst = 1'b0;
  endtask

  task automatic test_idle();
    run = 1'b0;
    for (int i = 0; i < 100; i++) begin
      adv();
      nchecks++;
      if ({clkout, tick, busy, pending, cfg_ready} !== expv()) begin
        nerr++;
        $display("FAIL idle cyc=%0d got=%b exp=%b", i, {clkout, tick, busy, pending, cfg_ready}, expv());
      end
    end
  endtask

  task automatic test_limit4();
    int rise_at = 0;
    int ticks   = 0;
    cfg_valid = 1'b1; cfg_limit = 4;
    adv();
    cfg_valid = 1'b0;
    nchecks++;
    if ({clkout, tick, busy, pending, cfg_ready} !== expv()) begin
      nerr++;
      $display("FAIL limit4_accept got=%b exp=%b", {clkout, tick, busy, pending, cfg_ready}, expv());
    end
    adv();
    nchecks++;
    if ({clkout, tick, busy, pending, cfg_ready} !== expv()) begin
      nerr++;
      $display("FAIL limit4_idle_apply got=%b exp=%b", {clkout, tick, busy, pending, cfg_ready}, expv());
    end
    run = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      adv();
      nchecks++;
      if ({clkout, tick, busy, pending, cfg_ready} !== expv()) begin
        nerr++;
        $display("FAIL limit4 cyc=%0d got=%b exp=%b", i, {clkout, tick, busy, pending, cfg_ready}, expv());
      end
      if (rise_at == 0 && clkout) rise_at = i;
      if (tick) ticks++;
    end
    nchecks++;
    if (rise_at != 5) begin
      nerr++;
      $display("FAIL limit4_first_rise got=%0d exp=%0d", rise_at, 5);
    end
    nchecks++;
    if (ticks != 9) begin
      nerr++;
      $display("FAIL limit4_tick_count got=%0d exp=%0d", ticks, 9);
    end
  endtask

  task automatic test_shrink();
    bit found = 0;
    bit seen  = 0;
    bit prev;
    int len   = 0;
    int min_ph = 1000;
    for (int i = 0; i < 20 && !found; i++) begin
      adv();
      nchecks++;
      if ({clkout, tick, busy, pending, cfg_ready} !== expv()) begin
        nerr++;
        $display("FAIL shrink_wait cyc=%0d got=%b exp=%b", i, {clkout, tick, busy, pending, cfg_ready}, expv());
      end
      if (clkout) found = 1;
    end
    nchecks++;
    if (!found) begin
      nerr++;
      $display("FAIL shrink_no_high got=0 exp=1");
    end
    adv();
    cfg_valid = 1'b1; cfg_limit = 2;
    adv();
    cfg_valid = 1'b0;
    prev = clkout;
    for (int i = 0; i < 40; i++) begin
      adv();
      nchecks++;
      if ({clkout, tick, busy, pending, cfg_ready} !== expv()) begin
        nerr++;
        $display("FAIL shrink cyc=%0d got=%b exp=%b", i, {clkout, tick, busy, pending, cfg_ready}, expv());
      end
      if (clkout != prev) begin
        if (seen && len < min_ph) min_ph = len;
        seen = 1; len = 1;
      end else begin
        len++;
      end
      prev = clkout;
    end
    nchecks++;
    if (min_ph != 2) begin
      nerr++;
      $display("FAIL shrink_min_phase got=%0d exp=%0d", min_ph, 2);
    end
  endtask

  task automatic test_stop();
    bit done = 0;
    bit prev;
    int hi = 0;
    cfg_valid = 1'b1; cfg_limit = 4;
    adv();
    cfg_valid = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      adv();
      nchecks++;
      if ({clkout, tick, busy, pending, cfg_ready} !== expv()) begin
        nerr++;
        $display("FAIL stop_apply cyc=%0d got=%b exp=%b", i, {clkout, tick, busy, pending, cfg_ready}, expv());
      end
      if (!pending) done = 1;
    end
    done = 0;
    prev = clkout;
    for (int i = 0; i < 30 && !done; i++) begin
      adv();
      nchecks++;
      if ({clkout, tick, busy, pending, cfg_ready} !== expv()) begin
        nerr++;
        $display("FAIL stop_rise cyc=%0d got=%b exp=%b", i, {clkout, tick, busy, pending, cfg_ready}, expv());
      end
      if (clkout && !prev) done = 1;
      prev = clkout;
    end
    nchecks++;
    if (!done) begin
      nerr++;
      $display("FAIL stop_no_rise got=0 exp=1");
    end
    hi = 1;
    adv();
    if (clkout) hi++;
    run = 1'b0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      adv();
      nchecks++;
      if ({clkout, tick, busy, pending, cfg_ready} !== expv()) begin
        nerr++;
        $display("FAIL stop_drain cyc=%0d got=%b exp=%b", i, {clkout, tick, busy, pending, cfg_ready}, expv());
      end
      if (clkout) hi++;
      else done = 1;
    end
    nchecks++;
    if (hi != 4) begin
      nerr++;
      $display("FAIL stop_high_phase got=%0d exp=%0d", hi, 4);
    end
    for (int i = 0; i < 20; i++) begin
      adv();
      nchecks++;
      if ({clkout, tick, busy, pending, cfg_ready} !== 5'b00001) begin
        nerr++;
        $display("FAIL stop_idle cyc=%0d got=%b exp=%b", i, {clkout, tick, busy, pending, cfg_ready}, 5'b00001);
      end
    end
  endtask

  task automatic test_zero();
    int ticks = 0;
    bit done  = 0;
    cfg_valid = 1'b1; cfg_limit = 0;
    adv();
    cfg_valid = 1'b0;
    adv();
    run = 1'b1;
    adv();
    for (int i = 0; i < 10; i++) begin
      adv();
      nchecks++;
      if ({clkout, tick, busy, pending, cfg_ready} !== expv()) begin
        nerr++;
        $display("FAIL zero cyc=%0d got=%b exp=%b", i, {clkout, tick, busy, pending, cfg_ready}, expv());
      end
      if (tick) ticks++;
    end
    nchecks++;
    if (ticks != 10) begin
      nerr++;
      $display("FAIL zero_tick_count got=%0d exp=%0d", ticks, 10);
    end
    run = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      adv();
      nchecks++;
      if ({clkout, tick, busy, pending, cfg_ready} !== expv()) begin
        nerr++;
        $display("FAIL zero_stop cyc=%0d got=%b exp=%b", i, {clkout, tick, busy, pending, cfg_ready}, expv());
      end
      if (!busy) done = 1;
    end
  endtask

  task automatic test_random();
    bit done = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) run = !run;
      if ($urandom_range(0, 5) == 0) begin
        cfg_valid = 1'b1;
        cfg_limit = $urandom_range(0, 6);
      end else begin
        cfg_valid = 1'b0;
      end
      adv();
      nchecks++;
      if ({clkout, tick, busy, pending, cfg_ready} !== expv()) begin
        nerr++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, {clkout, tick, busy, pending, cfg_ready}, expv());
      end
    end
    run = 1'b0; cfg_valid = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      adv();
      nchecks++;
      if ({clkout, tick, busy, pending, cfg_ready} !== expv()) begin
        nerr++;
        $display("FAIL random_drain cyc=%0d got=%b exp=%b", i, {clkout, tick, busy, pending, cfg_ready}, expv());
      end
      if (!busy && !pending) done = 1;
    end
    nchecks++;
    if (!done) begin
      nerr++;
      $display("FAIL random_drain_timeout got=busy exp=idle");
    end
  endtask

  task automatic test_reset_midrun();
    int rise_at = 0;
    cfg_valid = 1'b1; cfg_limit = 5;
    adv();
    cfg_valid = 1'b0; run = 1'b1;
    adv();
    for (int i = 0; i < 7; i++) adv();
    cfg_valid = 1'b1; cfg_limit = 3;
    adv();
    cfg_valid = 1'b0;
    nchecks++;
    if ({clkout, tick, busy, pending, cfg_ready} !== expv()) begin
      nerr++;
      $display("FAIL midrun_pending got=%b exp=%b", {clkout, tick, busy, pending, cfg_ready}, expv());
    end
    #2;
    rst = 1'b1;
    #1;
    nchecks++;
    if ({clkout, tick, busy, pending, cfg_ready} !== 5'b00001) begin
      nerr++;
      $display("FAIL async_reset got=%b exp=%b", {clkout, tick, busy, pending, cfg_ready}, 5'b00001);
    end
    model_reset();
    @(negedge clkin);
    rst = 1'b0;
    for (int i = 1; i <= int'(DEF_LIM) + 20 && rise_at == 0; i++) begin
      adv();
      nchecks++;
      if ({clkout, tick, busy, pending, cfg_ready} !== expv()) begin
        nerr++;
        $display("FAIL post_reset cyc=%0d got=%b exp=%b", i, {clkout, tick, busy, pending, cfg_ready}, expv());
      end
      if (clkout) rise_at = i;
    end
    nchecks++;
    if (rise_at != int'(DEF_LIM) + 1) begin
      nerr++;
      $display("FAIL default_first_rise got=%0d exp=%0d", rise_at, int'(DEF_LIM) + 1);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_limit4();
    test_shrink();
    test_stop();
    test_zero();
    test_random();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
